// File: rtl/cdc_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_fifo_pkg
//  Description : Shared widths, types and helpers for the CDC FIFO read-side
//                drain master (cdc_fifo_drain and cdc_fifo_rdclk_gen).
//  Contents    : NIBBLE_W / BYTE_W widths, nibble_t / byte_t typedefs,
//                default read-clock half period, nibble packing helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cdc_fifo_pkg;

    localparam int NIBBLE_W         = 4;
    localparam int BYTE_W           = 8;

    // Default number of clk cycles per read_clock half-period.
    localparam int CLK_HALF_DEFAULT = 2;

    typedef logic [NIBBLE_W-1:0] nibble_t;
    typedef logic [BYTE_W-1:0]   byte_t;

    // Assemble a byte from two nibbles in pop order. With low_first set the
    // earlier nibble lands in the low half of the byte.
    function automatic byte_t pack_nibbles(
        input nibble_t first_nib,
        input nibble_t second_nib,
        input logic    low_first
    );
        byte_t result;
        if (low_first) begin
            result = {second_nib, first_nib};
        end else begin
            result = {first_nib, second_nib};
        end
        return result;
    endfunction

endpackage : cdc_fifo_pkg
`default_nettype wire

// File: rtl/cdc_fifo_rdclk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_fifo_rdclk_gen
//  Description : Divides clk down to the FIFO read clock and flags the clk
//                cycles in which that read clock is about to rise or fall.
//  Ports       : clk             - system clock
//                rst_n           - asynchronous active-low reset
//                fifo_read_clock - registered read clock, 50% duty,
//                                  period 2*CLK_HALF clk cycles
//                rise_tick       - this cycle's edge makes read clock rise
//                fall_tick       - this cycle's edge makes read clock fall
//  Parameters  : CLK_HALF        - clk cycles per read clock half-period (>=2)
//  Revision    : 1.0 - initial release
// ============================================================================
module cdc_fifo_rdclk_gen
    import cdc_fifo_pkg::*;
#(
    parameter int CLK_HALF = CLK_HALF_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    output logic fifo_read_clock,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int               CNT_W      = (CLK_HALF > 2) ? $clog2(CLK_HALF) : 1;
    localparam logic [CNT_W-1:0] C_TERMINAL = CNT_W'(CLK_HALF - 1);
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

    logic [CNT_W-1:0] r_div;
    logic             r_read_clock;
    logic             w_terminal;

    assign w_terminal = (r_div == C_TERMINAL);

    // Free-running from reset release: count 0..CLK_HALF-1 and toggle the
    // read clock on every terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div        <= '0;
            r_read_clock <= 1'b0;
        end else if (w_terminal) begin
            r_div        <= '0;
            r_read_clock <= ~r_read_clock;
        end else begin
            r_div        <= r_div + C_ONE;
        end
    end

    assign fifo_read_clock = r_read_clock;
    assign rise_tick       = w_terminal && !r_read_clock;
    assign fall_tick       = w_terminal &&  r_read_clock;

endmodule : cdc_fifo_rdclk_gen
`default_nettype wire

// File: rtl/cdc_fifo_drain.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_fifo_drain
//  Description : Read-side master for the nibble-wide CDC FIFO. Generates the
//                FIFO read clock from clk, pops nibbles on read clock falling
//                ticks, pairs them into bytes and offers them on a
//                valid/ready stream.
//  Ports       : clk                 - system clock (only clock used)
//                rst_n               - asynchronous active-low reset
//                enable              - 1 allows new pops
//                fifo_empty          - FIFO empty flag (read clock domain)
//                fifo_read_data[3:0] - FIFO head nibble (fall-through)
//                fifo_read_clock     - generated read clock (registered)
//                fifo_read_increment - pop request (registered)
//                out_data[7:0]       - assembled byte
//                out_valid           - out_data holds a byte
//                out_ready           - consumer accepts byte on valid&&ready
//                nibble_pending      - one nibble waiting for its partner
//  Optional    : CDC_FIFO_DRAIN_STATS_EN adds
//                byte_count[7:0]     - saturating handshake counter
//                underrun            - sticky: FIFO ran dry mid-byte
//  Parameters  : CLK_HALF  - clk cycles per read clock half-period (>=2)
//                LOW_FIRST - 1: first popped nibble -> out_data[3:0]
//                            0: first popped nibble -> out_data[7:4]
//  Revision    : 1.0 - initial release
// ============================================================================
module cdc_fifo_drain
    import cdc_fifo_pkg::*;
#(
    parameter int CLK_HALF  = CLK_HALF_DEFAULT,
    parameter int LOW_FIRST = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                fifo_empty,
    input  logic [NIBBLE_W-1:0] fifo_read_data,
    output logic                fifo_read_clock,
    output logic                fifo_read_increment,
    output logic [BYTE_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                nibble_pending
`ifdef CDC_FIFO_DRAIN_STATS_EN
    ,
    output logic [7:0]          byte_count,
    output logic                underrun
`endif
);

    localparam logic C_LOW_FIRST = (LOW_FIRST != 0);

    logic    w_rise_tick;
    logic    w_fall_tick;

    logic    r_armed;
    logic    r_increment;
    logic    r_pending;
    logic    r_valid;
    nibble_t r_held;
    byte_t   r_data;

    logic    w_space;
    logic    w_pop;
    logic    w_load;
    logic    w_accept;

    cdc_fifo_rdclk_gen #(
        .CLK_HALF        (CLK_HALF)
    ) u_rdclk_gen (
        .clk             (clk),
        .rst_n           (rst_n),
        .fifo_read_clock (fifo_read_clock),
        .rise_tick       (w_rise_tick),
        .fall_tick       (w_fall_tick)
    );

    // The FIFO flags are only meaningful once the FIFO has seen at least one
    // read clock rising edge since reset; the first fall tick always follows
    // that rise, so this only guards against decisions on a stale fall tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
        end else if (w_rise_tick) begin
            r_armed <= 1'b1;
        end
    end

    always_comb begin
        // A second nibble may only be popped if the byte it completes has
        // somewhere to go: the output register is free or leaving this cycle.
        w_space  = !r_pending || !r_valid || out_ready;
        w_pop    = w_fall_tick && r_armed && enable && !fifo_empty && w_space;
        w_load   = w_pop && r_pending;
        w_accept = r_valid && out_ready;
    end

    // Pop request only changes on fall ticks, so it is held across exactly
    // one read clock rising edge per pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_increment <= 1'b0;
        end else if (w_fall_tick) begin
            r_increment <= w_pop;
        end
    end

    // Nibble pairing: the first nibble of a byte is parked in r_held, the
    // second completes the byte straight into the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_held    <= '0;
            r_pending <= 1'b0;
        end else if (w_pop) begin
            if (!r_pending) begin
                r_held    <= fifo_read_data;
                r_pending <= 1'b1;
            end else begin
                r_pending <= 1'b0;
            end
        end
    end

    // Stream register: a load in the handshake cycle keeps valid high with
    // the new byte; otherwise a handshake empties the register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_data  <= pack_nibbles(r_held, fifo_read_data, C_LOW_FIRST);
            r_valid <= 1'b1;
        end else if (w_accept) begin
            r_valid <= 1'b0;
        end
    end

    assign fifo_read_increment = r_increment;
    assign out_data            = r_data;
    assign out_valid           = r_valid;
    assign nibble_pending      = r_pending;

`ifdef CDC_FIFO_DRAIN_STATS_EN
    logic [7:0] r_byte_count;
    logic       r_underrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_count <= 8'h00;
        end else if (w_accept && (r_byte_count != 8'hFF)) begin
            r_byte_count <= r_byte_count + 8'h01;
        end
    end

    // Sticky: the FIFO went dry while half a byte was waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underrun <= 1'b0;
        end else if (w_fall_tick && enable && fifo_empty && r_pending) begin
            r_underrun <= 1'b1;
        end
    end

    assign byte_count = r_byte_count;
    assign underrun   = r_underrun;
`endif

endmodule : cdc_fifo_drain
`default_nettype wire

// File: tb/tb_cdc_fifo_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdc_fifo_drain
//  Description : Self-checking bench for cdc_fifo_drain. Two instances
//                (LOW_FIRST=1 and LOW_FIRST=0) drain identical FIFO models.
//                Expected bytes come from a pairing model of the pushed
//                nibble stream; table vectors, hand sequences and a random
//                phase are applied.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_fifo_drain;
    import cdc_fifo_pkg::*;

    localparam int CLK_HALF = 2;
    localparam int MEM_N    = 4096;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       enable    = 1'b0;
    logic       out_ready = 1'b0;

    logic       empty1, empty0;
    logic [3:0] rdata1, rdata0;
    logic       rclk1, rclk0, inc1, inc0;
    logic [7:0] data1, data0;
    logic       valid1, valid0, pend1, pend0;
`ifdef CDC_FIFO_DRAIN_STATS_EN
    logic [7:0] bcnt1, bcnt0;
    logic       urun1, urun0;
`endif

    // FIFO models: the initial block owns the write side, one always block
    // per instance owns the read side.
    logic [3:0] mem1 [MEM_N];
    logic [3:0] mem0 [MEM_N];
    int         wr1 = 0, wr0 = 0, rd1 = 0, rd0 = 0;
    int         incedges1 = 0;

    // Byte-level reference: pushed nibbles paired in order.
    logic [7:0] exp1 [MEM_N];
    logic [7:0] exp0 [MEM_N];
    int         ew = 0, er1 = 0, er0 = 0;
    logic [3:0] half_nib = 4'h0;
    bit         half_v   = 1'b0;

    bit         stall1 = 1'b0, stall0 = 1'b0;
    logic [7:0] hold1  = 8'h00, hold0 = 8'h00;

    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    assign empty1 = (rd1 == wr1);
    assign empty0 = (rd0 == wr0);
    assign rdata1 = mem1[rd1 % MEM_N];
    assign rdata0 = mem0[rd0 % MEM_N];

    always @(posedge rclk1) begin
        if (inc1) begin
            incedges1 = incedges1 + 1;
            if (rd1 != wr1) rd1 = rd1 + 1;
        end
    end

    always @(posedge rclk0) begin
        if (inc0 && (rd0 != wr0)) rd0 = rd0 + 1;
    end

    cdc_fifo_drain #(.CLK_HALF(CLK_HALF), .LOW_FIRST(1)) u_dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .enable              (enable),
        .fifo_empty          (empty1),
        .fifo_read_data      (rdata1),
        .fifo_read_clock     (rclk1),
        .fifo_read_increment (inc1),
        .out_data            (data1),
        .out_valid           (valid1),
        .out_ready           (out_ready),
        .nibble_pending      (pend1)
`ifdef CDC_FIFO_DRAIN_STATS_EN
        ,
        .byte_count          (bcnt1),
        .underrun            (urun1)
`endif
    );

    cdc_fifo_drain #(.CLK_HALF(CLK_HALF), .LOW_FIRST(0)) u_dut_hf (
        .clk                 (clk),
        .rst_n               (rst_n),
        .enable              (enable),
        .fifo_empty          (empty0),
        .fifo_read_data      (rdata0),
        .fifo_read_clock     (rclk0),
        .fifo_read_increment (inc0),
        .out_data            (data0),
        .out_valid           (valid0),
        .out_ready           (out_ready),
        .nibble_pending      (pend0)
`ifdef CDC_FIFO_DRAIN_STATS_EN
        ,
        .byte_count          (bcnt0),
        .underrun            (urun0)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_nib(input logic [3:0] n);
        mem1[wr1 % MEM_N] = n;
        mem0[wr0 % MEM_N] = n;
        wr1 = wr1 + 1;
        wr0 = wr0 + 1;
        if (half_v) begin
            exp1[ew % MEM_N] = {n, half_nib};
            exp0[ew % MEM_N] = {half_nib, n};
            ew     = ew + 1;
            half_v = 1'b0;
        end else begin
            half_nib = n;
            half_v   = 1'b1;
        end
    endtask

    // Scoreboard the state presented to the coming posedge, then advance to
    // the next negedge where outputs are settled.
    task automatic tick();
        if (stall1) check("stable_valid_lf1", {31'd0, valid1}, 32'd1);
        if (stall1) check("stable_data_lf1", {24'd0, data1}, {24'd0, hold1});
        if (stall0) check("stable_data_lf0", {24'd0, data0}, {24'd0, hold0});
        if (valid1 && out_ready) begin
            check("byte_expected_lf1", {31'd0, (er1 < ew)}, 32'd1);
            if (er1 < ew) begin
                check("sb_byte_lf1", {24'd0, data1}, {24'd0, exp1[er1 % MEM_N]});
                er1 = er1 + 1;
            end
        end
        if (valid0 && out_ready) begin
            check("byte_expected_lf0", {31'd0, (er0 < ew)}, 32'd1);
            if (er0 < ew) begin
                check("sb_byte_lf0", {24'd0, data0}, {24'd0, exp0[er0 % MEM_N]});
                er0 = er0 + 1;
            end
        end
        stall1 = valid1 && !out_ready;
        stall0 = valid0 && !out_ready;
        hold1  = data1;
        hold0  = data0;
        @(negedge clk);
    endtask

    task automatic assert_reset_and_flush();
        rst_n     = 1'b0;
        enable    = 1'b0;
        out_ready = 1'b0;
        #1;
        wr1    = rd1;
        wr0    = rd0;
        er1    = ew;
        er0    = ew;
        half_v = 1'b0;
        stall1 = 1'b0;
        stall0 = 1'b0;
    endtask

    task automatic do_reset();
        assert_reset_and_flush();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (valid1) seen = 1'b1;
        end
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] lf1;
        logic [7:0] lf0;
    } vec_t;

    vec_t vecs [6];

    initial begin
        bit seen;
        int base, toggles, inc_hi, val_hi, n_push;
        logic prev_rclk;

        vecs[0] = '{a: 4'h3, b: 4'hA, lf1: 8'hA3, lf0: 8'h3A};
        vecs[1] = '{a: 4'h1, b: 4'h2, lf1: 8'h21, lf0: 8'h12};
        vecs[2] = '{a: 4'hF, b: 4'h0, lf1: 8'h0F, lf0: 8'hF0};
        vecs[3] = '{a: 4'h0, b: 4'hF, lf1: 8'hF0, lf0: 8'h0F};
        vecs[4] = '{a: 4'h5, b: 4'h5, lf1: 8'h55, lf0: 8'h55};
        vecs[5] = '{a: 4'hC, b: 4'h6, lf1: 8'h6C, lf0: 8'hC6};

        // Reset state
        assert_reset_and_flush();
        repeat (3) @(negedge clk);
        check("rst_read_clock", {31'd0, rclk1}, 32'd0);
        check("rst_increment", {31'd0, inc1}, 32'd0);
        check("rst_out_data", {24'd0, data1}, 32'd0);
        check("rst_out_valid", {31'd0, valid1}, 32'd0);
        check("rst_pending", {31'd0, pend1}, 32'd0);
        rst_n = 1'b1;

        // Empty FIFO: read clock free-runs, nothing popped or produced
        enable    = 1'b1;
        out_ready = 1'b1;
        toggles   = 0;
        inc_hi    = 0;
        val_hi    = 0;
        prev_rclk = rclk1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rclk1 != prev_rclk) toggles++;
            if (inc1) inc_hi++;
            if (valid1) val_hi++;
            prev_rclk = rclk1;
        end
        check("empty_rclk_toggles", toggles, 40 / CLK_HALF);
        check("empty_inc_cycles", inc_hi, 0);
        check("empty_valid_cycles", val_hi, 0);

        // Table vectors: one byte per row, both nibble orders
        for (int v = 0; v < 6; v++) begin
            base = incedges1;
            push_nib(vecs[v].a);
            push_nib(vecs[v].b);
            wait_valid(60, seen);
            check($sformatf("vec%0d_seen", v), {31'd0, seen}, 32'd1);
            check($sformatf("vec%0d_lf1", v), {24'd0, data1}, {24'd0, vecs[v].lf1});
            check($sformatf("vec%0d_lf0", v), {24'd0, data0}, {24'd0, vecs[v].lf0});
            repeat (12) tick();
            check($sformatf("vec%0d_inc_edges", v), incedges1 - base, 32'd2);
            check($sformatf("vec%0d_valid_pulse", v), {31'd0, valid1}, 32'd0);
        end

        // Back-pressure: one byte plus one nibble held, rest stays in FIFO
        do_reset();
        enable    = 1'b1;
        out_ready = 1'b0;
        for (int n = 1; n <= 6; n++) push_nib(4'(n));
        repeat (60) tick();
        check("bp_valid", {31'd0, valid1}, 32'd1);
        check("bp_data", {24'd0, data1}, 32'h21);
        check("bp_pending", {31'd0, pend1}, 32'd1);
        check("bp_fifo_left", wr1 - rd1, 32'd3);
        check("bp_increment", {31'd0, inc1}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 80 && er1 < ew; i++) tick();
        repeat (4) tick();
        check("bp_all_delivered", er1, ew);
        check("bp_pending_done", {31'd0, pend1}, 32'd0);

        // enable dropped mid-byte keeps the held nibble
        seen = 1'b0;
        push_nib(4'h9);
        push_nib(4'hC);
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (pend1) seen = 1'b1;
        end
        enable = 1'b0;
        check("en_mid_seen", {31'd0, seen}, 32'd1);
        repeat (30) tick();
        check("en_mid_pending", {31'd0, pend1}, 32'd1);
        check("en_mid_valid", {31'd0, valid1}, 32'd0);
        check("en_mid_fifo_left", wr1 - rd1, 32'd1);
        enable = 1'b1;
        wait_valid(40, seen);
        check("en_resume_seen", {31'd0, seen}, 32'd1);
        check("en_resume_data", {24'd0, data1}, 32'hC9);

        // Reset while a nibble is held and the increment is high
        push_nib(4'h5);
        push_nib(4'hE);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (pend1 && inc1) seen = 1'b1;
        end
        check("rst_mid_seen", {31'd0, seen}, 32'd1);
        assert_reset_and_flush();
        check("rst_mid_increment", {31'd0, inc1}, 32'd0);
        check("rst_mid_pending", {31'd0, pend1}, 32'd0);
        check("rst_mid_valid", {31'd0, valid1}, 32'd0);
        check("rst_mid_data", {24'd0, data1}, 32'd0);
        check("rst_mid_rclk", {31'd0, rclk1}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n     = 1'b1;
        enable    = 1'b1;
        out_ready = 1'b1;
        push_nib(4'h7);
        push_nib(4'h8);
        wait_valid(40, seen);
        check("rst_after_seen", {31'd0, seen}, 32'd1);
        check("rst_after_data", {24'd0, data1}, 32'h87);

        // Randomized traffic against the pairing model
        do_reset();
        n_push = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                push_nib(4'($urandom_range(0, 15)));
                n_push++;
            end
            enable    = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) == 1);
            tick();
        end
        if (half_v) push_nib(4'($urandom_range(0, 15)));
        enable    = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 1500 && (er1 < ew || er0 < ew); i++) tick();
        repeat (4) tick();
        check("rand_drained_lf1", er1, ew);
        check("rand_drained_lf0", er0, ew);
        check("rand_fifo_empty", wr1 - rd1, 32'd0);
        check("rand_pending", {31'd0, pend1}, 32'd0);

`ifdef CDC_FIFO_DRAIN_STATS_EN
        do_reset();
        check("stats_rst_count", {24'd0, bcnt1}, 32'd0);
        check("stats_rst_underrun", {31'd0, urun1}, 32'd0);
        enable    = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 600; n++) push_nib(4'(n % 16));
        for (int i = 0; i < 4000 && er1 < ew; i++) tick();
        repeat (4) tick();
        check("stats_all_delivered", er1, ew);
        check("stats_count_sat", {24'd0, bcnt1}, 32'hFF);
        check("stats_no_underrun", {31'd0, urun1}, 32'd0);
        push_nib(4'h4);
        repeat (30) tick();
        check("stats_pending", {31'd0, pend1}, 32'd1);
        check("stats_underrun", {31'd0, urun1}, 32'd1);
        check("stats_underrun_lf0", {31'd0, urun0}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule : tb_cdc_fifo_drain
`default_nettype wire
